ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/ram_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared widths and the FSM state type for the ram_arbiter slice.
// The CLEAR state exists only when RAM_ARBITER_CLEAR_EN is defined.
// No ports (package).
package ram_arbiter_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

`ifdef RAM_ARBITER_CLEAR_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    CLEAR  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin grant. With both requests high, the requester that
// was not granted last wins; a lone request always wins.
// Ports:
//   req  [1:0] in  - request per requester
//   last       in  - index of the requester granted most recently
//   gnt  [1:0] out - one-hot grant (all zero when no request)
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_gnt
      localparam logic SELF = 1'(gi);
      // Win if the other side is quiet, or if we were not the last winner.
      assign gnt[gi] = req[gi] & (~req[1-gi] | (last != SELF));
    end
  endgenerate

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port RAM between two requesters with round-robin
// arbitration, and optionally runs a zero-fill sweep of addresses
// 0..CLEAR_LAST. The sweep is compiled in only with RAM_ARBITER_CLEAR_EN;
// without it clear_start is ignored and clear_busy/clear_done read 0.
// Ports:
//   clk                    in    clock, rising edge
//   r                      in    asynchronous active-low reset
//   req0/req1              in    requests, held until the matching ack
//   we0/we1                in    1 = write, 0 = read
//   addr0/addr1  [23:0]    in    word address
//   wdata0/wdata1 [15:0]   in    write data
//   ack0/ack1              out   one-cycle completion pulse
//   rdata        [15:0]    out   read data, valid with ack, held otherwise
//   clear_start            in    pulse requesting a zero-fill sweep
//   clear_busy             out   high while the sweep runs
//   clear_done             out   one-cycle pulse after the last clear write
//   ram_we/ram_oe          out   RAM write / output enable
//   ram_addr     [23:0]    out   RAM address
//   ram_data     [15:0]    inout RAM data bus, driven only while ram_we
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter logic [ADDR_W-1:0] CLEAR_LAST = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              r,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  state_t              state_reg, state_next;
  logic                ack0_reg, ack0_next;
  logic                ack1_reg, ack1_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                ram_we_reg, ram_we_next;
  logic                ram_oe_reg, ram_oe_next;
  logic [ADDR_W-1:0]   ram_addr_reg, ram_addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  // Index of the most recent winner; also identifies the owner of ACCESS.
  logic                last_reg, last_next;
  logic [1:0]          req_eff;
  logic [1:0]          gnt;

`ifdef RAM_ARBITER_CLEAR_EN
  logic                clear_pend_reg, clear_pend_next;
  logic                clear_busy_reg, clear_busy_next;
  logic                clear_done_reg, clear_done_next;
`endif

  // A requester keeps req high during its ack cycle; masking it there stops
  // the same request from being served twice.
  assign req_eff = {req1 & ~ack1_reg, req0 & ~ack0_reg};

  rr_arbiter2 u_rr (
    .req  (req_eff),
    .last (last_reg),
    .gnt  (gnt)
  );

  always_comb begin
    state_next    = state_reg;
    ack0_next     = 1'b0;
    ack1_next     = 1'b0;
    rdata_next    = rdata_reg;
    ram_we_next   = ram_we_reg;
    ram_oe_next   = ram_oe_reg;
    ram_addr_next = ram_addr_reg;
    wdata_next    = wdata_reg;
    last_next     = last_reg;
`ifdef RAM_ARBITER_CLEAR_EN
    clear_pend_next = clear_pend_reg;
    clear_busy_next = clear_busy_reg;
    clear_done_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
`ifdef RAM_ARBITER_CLEAR_EN
        if (clear_pend_reg || clear_start) begin
          state_next      = CLEAR;
          clear_pend_next = 1'b0;
          clear_busy_next = 1'b1;
          ram_we_next     = 1'b1;
          ram_oe_next     = 1'b0;
          ram_addr_next   = '0;
          wdata_next      = '0;
        end else
`endif
        if (gnt[0] || gnt[1]) begin
          state_next    = ACCESS;
          last_next     = gnt[1];
          ram_addr_next = gnt[1] ? addr1 : addr0;
          ram_we_next   = gnt[1] ? we1 : we0;
          ram_oe_next   = gnt[1] ? ~we1 : ~we0;
          wdata_next    = gnt[1] ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        state_next  = IDLE;
        ram_we_next = 1'b0;
        ram_oe_next = 1'b0;
        ack0_next   = ~last_reg;
        ack1_next   = last_reg;
        if (ram_oe_reg) begin
          rdata_next = ram_data;
        end
`ifdef RAM_ARBITER_CLEAR_EN
        if (clear_start) begin
          clear_pend_next = 1'b1;
        end
`endif
      end
`ifdef RAM_ARBITER_CLEAR_EN
      CLEAR: begin
        // Terminate on the compare so CLEAR_LAST = all-ones never wraps.
        if (ram_addr_reg == CLEAR_LAST) begin
          state_next      = IDLE;
          ram_we_next     = 1'b0;
          clear_busy_next = 1'b0;
          clear_done_next = 1'b1;
        end else begin
          ram_addr_next = ram_addr_reg + ADDR_W'(1);
        end
      end
`endif
      default: begin
        state_next  = IDLE;
        ram_we_next = 1'b0;
        ram_oe_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_reg    <= IDLE;
      ack0_reg     <= 1'b0;
      ack1_reg     <= 1'b0;
      rdata_reg    <= '0;
      ram_we_reg   <= 1'b0;
      ram_oe_reg   <= 1'b0;
      ram_addr_reg <= '0;
      wdata_reg    <= '0;
      last_reg     <= 1'b1;  // requester 0 wins the first tie
    end else begin
      state_reg    <= state_next;
      ack0_reg     <= ack0_next;
      ack1_reg     <= ack1_next;
      rdata_reg    <= rdata_next;
      ram_we_reg   <= ram_we_next;
      ram_oe_reg   <= ram_oe_next;
      ram_addr_reg <= ram_addr_next;
      wdata_reg    <= wdata_next;
      last_reg     <= last_next;
    end
  end

`ifdef RAM_ARBITER_CLEAR_EN
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      clear_pend_reg <= 1'b0;
      clear_busy_reg <= 1'b0;
      clear_done_reg <= 1'b0;
    end else begin
      clear_pend_reg <= clear_pend_next;
      clear_busy_reg <= clear_busy_next;
      clear_done_reg <= clear_done_next;
    end
  end

  assign clear_busy = clear_busy_reg;
  assign clear_done = clear_done_reg;
`else
  logic unused_clear;
  assign unused_clear = clear_start | (|CLEAR_LAST);
  assign clear_busy   = 1'b0;
  assign clear_done   = 1'b0;
`endif

  assign ack0     = ack0_reg;
  assign ack1     = ack1_reg;
  assign rdata    = rdata_reg;
  assign ram_we   = ram_we_reg;
  assign ram_oe   = ram_oe_reg;
  assign ram_addr = ram_addr_reg;
  assign ram_data = ram_we_reg ? wdata_reg : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed bench for ram_arbiter with a 256-word RAM model indexed by the
// low address byte. When the arbiter releases ram_data, the model parks the
// bus at PARK so a stray arbiter driver shows up as a wrong value.
// Runs the clear sweep checks when RAM_ARBITER_CLEAR_EN is defined, and the
// clear-ignored checks otherwise.
module tb_ram_arbiter;

  localparam logic [15:0] PARK = 16'hA5A5;

  logic        clk = 1'b0;
  logic        r = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [23:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        clear_start = 1'b0;
  logic        ack0, ack1, clear_busy, clear_done, ram_we, ram_oe;
  logic [15:0] rdata;
  logic [23:0] ram_addr;
  wire  [15:0] ram_data;

  logic [15:0] mem [0:255];
  bit          mem_init = 1'b0;
  bit          mon_en = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.CLEAR_LAST(24'h00000F)) dut (
    .clk(clk), .r(r),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr), .ram_data(ram_data)
  );

  function automatic logic [15:0] preload(input int i);
    if (i < 16) return 16'h0100 + 16'(i);
    case (i)
      16:      return 16'hBEEF;
      32:      return 16'h1111;
      33:      return 16'h2222;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= preload(i);
      mem_init <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr[7:0]] <= ram_data;
    end
  end

  assign ram_data = ram_oe ? mem[ram_addr[7:0]] : (ram_we ? 16'hzzzz : PARK);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Bus invariants, every cycle once out of the initial reset.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("we_oe_exclusive", 32'(ram_we & ram_oe), 32'd0);
      if (!ram_we && !ram_oe) chk("bus_released", 32'(ram_data), 32'(PARK));
    end
  end

  task automatic do_req(input int who, input logic we, input logic [23:0] a,
                        input logic [15:0] d, input logic [15:0] exp_rd, input string tag);
    int          cyc = 0;
    int          oe_n = 0;
    int          we_n = 0;
    bit          got = 1'b0;
    logic [23:0] a_seen = '0;
    logic [15:0] rd = '0;
    if (who == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else          begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (ram_oe) oe_n++;
      if (ram_we) we_n++;
      if (ram_oe || ram_we) a_seen = ram_addr;
      if ((who == 0) ? ack0 : ack1) begin got = 1'b1; rd = rdata; end
    end
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    chk({tag, "_ack"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'd2);
    chk({tag, "_oe_cycles"}, 32'(oe_n), we ? 32'd0 : 32'd1);
    chk({tag, "_we_cycles"}, 32'(we_n), we ? 32'd1 : 32'd0);
    chk({tag, "_addr"}, 32'(a_seen), 32'(a));
    chk({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
    $display("txn %s: req%0d %s addr=%h wdata=%h rdata=%h latency=%0d",
             tag, who, we ? "write" : "read", a, d, rd, cyc);
    @(negedge clk);
  endtask

  initial begin
    int          k;
    int          c;
    int          busy_n;
    int          done_n;
    int          done_c;
    int          ack_c;
    int          we_n;
    logic [15:0] rd;

    #2 r = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_oe", 32'(ram_oe), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_clear_busy", 32'(clear_busy), 32'd0);
    chk("rst_clear_done", 32'(clear_done), 32'd0);
    chk("rst_bus", 32'(ram_data), 32'(PARK));
    r = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Single read, then write / read-back by requester 1.
    do_req(0, 1'b0, 24'h000010, 16'h0000, 16'hBEEF, "rd0");
    do_req(1, 1'b1, 24'h00ABCD, 16'h1234, 16'hBEEF, "wr1");
    chk("wr1_mem", 32'(mem[8'hCD]), 32'h1234);
    do_req(1, 1'b0, 24'h00ABCD, 16'h0000, 16'h1234, "rd1");

    // Contention: requester 1 went last, so order is 0,1,0,1 every 2 cycles.
    req0 = 1'b1; we0 = 1'b0; addr0 = 24'h000020;
    req1 = 1'b1; we1 = 1'b0; addr1 = 24'h000021;
    k = 0;
    c = 0;
    while (k < 4 && c < 30) begin
      @(negedge clk);
      c++;
      chk("cont_ack_onehot", 32'(ack0 & ack1), 32'd0);
      if (ack0 || ack1) begin
        chk($sformatf("cont_order%0d", k), 32'(ack1), 32'(k % 2));
        chk($sformatf("cont_time%0d", k), 32'(c), 32'(2 * (k + 1)));
        chk($sformatf("cont_rdata%0d", k), 32'(rdata), (k % 2) ? 32'h2222 : 32'h1111);
        $display("txn cont%0d: ack%0d rdata=%h cycle=%0d", k, ack1 ? 1 : 0, rdata, c);
        k++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("cont_grants", 32'(k), 32'd4);
    @(negedge clk);

    // Reset during the ACCESS cycle of a write.
    req0 = 1'b1; we0 = 1'b1; addr0 = 24'h000030; wdata0 = 16'h5555;
    @(negedge clk);
    chk("abort_in_access", 32'(ram_we), 32'd1);
    r = 1'b0;
    req0 = 1'b0;
    #1;
    chk("abort_ram_we", 32'(ram_we), 32'd0);
    chk("abort_ram_addr", 32'(ram_addr), 32'd0);
    chk("abort_rdata", 32'(rdata), 32'd0);
    chk("abort_acks", 32'({ack0, ack1}), 32'd0);
    chk("abort_bus", 32'(ram_data), 32'(PARK));
    @(negedge clk);
    chk("abort_no_ack", 32'({ack0, ack1}), 32'd0);
    chk("abort_mem", 32'(mem[8'h30]), 32'd0);
    $display("txn abort: write to 000030 aborted by reset");
    r = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 24'h000010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 24'h000021;
    c = 0;
    while (!(ack0 || ack1) && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("post_rst_prio", 32'({ack1, ack0}), 32'b01);
    chk("post_rst_time", 32'(c), 32'd2);
    chk("post_rst_rdata", 32'(rdata), 32'hBEEF);
    $display("txn post_reset: ack0=%0b ack1=%0b rdata=%h cycle=%0d", ack0, ack1, rdata, c);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);

`ifdef RAM_ARBITER_CLEAR_EN
    // Sweep 0..15 with req0 held and a second, merged clear_start pulse.
    clear_start = 1'b1;
    busy_n = 0; done_n = 0; done_c = 0; ack_c = 0; rd = 16'hFFFF;
    for (c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 1) begin
        clear_start = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 24'h000003;
      end
      if (c == 5) clear_start = 1'b1;
      if (c == 6) clear_start = 1'b0;
      if (clear_busy) begin
        chk("clr_addr", 32'(ram_addr), 32'(busy_n));
        chk("clr_we", 32'(ram_we), 32'd1);
        chk("clr_data", 32'(ram_data), 32'd0);
        busy_n++;
      end
      if (clear_done) begin done_n++; done_c = c; end
      if (ack0) begin ack_c = c; rd = rdata; req0 = 1'b0; end
    end
    chk("clr_busy_cycles", 32'(busy_n), 32'd16);
    chk("clr_done_pulses", 32'(done_n), 32'd1);
    chk("clr_done_cycle", 32'(done_c), 32'd17);
    chk("clr_req_ack_cycle", 32'(ack_c), 32'(done_c + 2));
    chk("clr_req_rdata", 32'(rd), 32'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("clr_mem%0d", i), 32'(mem[i]), 32'd0);
    chk("clr_mem_past_last", 32'(mem[16]), 32'hBEEF);
    $display("txn clear: busy=%0d done_cycle=%0d req0_ack_cycle=%0d", busy_n, done_c, ack_c);
`else
    // Clear compiled out: the pulse must have no visible effect.
    clear_start = 1'b1;
    busy_n = 0; done_n = 0; we_n = 0;
    for (c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) clear_start = 1'b0;
      if (clear_busy) busy_n++;
      if (clear_done) done_n++;
      if (ram_we) we_n++;
    end
    chk("noclr_busy", 32'(busy_n), 32'd0);
    chk("noclr_done", 32'(done_n), 32'd0);
    chk("noclr_we", 32'(we_n), 32'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("noclr_mem%0d", i), 32'(mem[i]), 32'(preload(i)));
    $display("txn clear_disabled: busy=%0d done=%0d writes=%0d", busy_n, done_n, we_n);
    do_req(0, 1'b0, 24'h000005, 16'h0000, 16'h0105, "noclr_rd0");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
